axi4_slave_mem: RTL and testbench
=================================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 Parameter ADDR_W, default 16, byte address width.
REQ-002 Parameter DATA_W, default 32, data width in bits; allowed values are 32 or 64.
REQ-003 Parameter ID_W, default 4, transaction ID width.
REQ-004 Parameter MEM_WORDS, default 1024, number of DATA_W-wide storage words.
REQ-005 clk  in  1  single clock; every flop updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 awid  in  ID_W  write address ID.
REQ-008 awaddr  in  ADDR_W  write start byte address.
REQ-009 awlen  in  8  write beats minus 1.
REQ-010 awvalid  in  1  / awready  out  1  AW handshake.
REQ-011 wdata  in  DATA_W  write data.
REQ-012 wstrb  in  DATA_W/8  byte-enable strobes.
REQ-013 wlast  in  1  initiator's final-beat flag.
REQ-014 wvalid  in  1  / wready  out  1  W handshake.
REQ-015 bid  out  ID_W  / bresp  out  2  write response.
REQ-016 bvalid  out  1  / bready  in  1  B handshake.
REQ-017 arid  in  ID_W  / araddr  in  ADDR_W  / arlen  in  8  read address.
REQ-018 arvalid  in  1  / arready  out  1  AR handshake.
REQ-019 rid  out  ID_W  / rdata  out  DATA_W  / rresp  out  2  / rlast  out  1  read data.
REQ-020 rvalid  out  1  / rready  in  1  R handshake.

Function
REQ-021 The block SHALL support INCR bursts of full-width beats only. No burst, size or lock inputs exist. The address increments by DATA_W/8 per beat, modulo 2^ADDR_W. 4 KB boundaries are not checked.
REQ-022 The word index SHALL be the address shifted right by log2(DATA_W/8). An index of MEM_WORDS or above is out-of-range.
REQ-023 Write FSM W_IDLE SHALL hold awready=1. On the AW handshake it captures awid, awaddr and awlen, clears the beat counter, and moves to W_DATA.
REQ-024 W_DATA SHALL hold wready=1. On each W handshake it writes the bytes enabled by wstrb to the current word, increments the address and beat counter, and moves to W_RESP after beat awlen.
REQ-025 The burst length SHALL be taken from awlen only. wlast low on the final beat, or high on any earlier beat, does not change beat count; it sets a sticky error flag.
REQ-026 An out-of-range write beat SHALL be discarded and SHALL set the sticky error flag.
REQ-027 W_RESP SHALL drive bvalid=1, bid equal to the captured ID, and bresp equal to 2'b10 (SLVERR) if the error flag is set, otherwise 2'b00. It holds these until bready, then returns to W_IDLE and clears the flag.
REQ-028 Read FSM R_IDLE SHALL hold arready=1. On the AR handshake it captures arid, araddr and arlen, and moves to R_DATA.
REQ-029 The first beat SHALL appear with rvalid=1 in the cycle after the AR handshake. rdata, rid, rresp and rlast are registered.
REQ-030 Each beat SHALL advance only on an rvalid&rready handshake. While rvalid=1 and rready=0, all R outputs are held stable.
REQ-031 rlast SHALL be 1 only on beat arlen. After the rlast handshake the FSM returns to R_IDLE, and rvalid is 0 in the following cycle.
REQ-032 An out-of-range read beat SHALL return rdata=0 and rresp=2'b10. In-range read beats return rresp=2'b00.
REQ-033 The read and write FSMs SHALL operate concurrently and independently.
REQ-034 When a read beat is loaded in the same cycle that a write hits the same word, the read SHALL return the old data.
REQ-035 awready SHALL be 0 outside W_IDLE, and arready SHALL be 0 outside R_IDLE.

Reset
REQ-036 While rst=1, the block SHALL drive awready, wready, bvalid, arready, rvalid and rlast to 0, and bid, bresp, rid, rresp and rdata to 0. Both FSMs go to IDLE and the error flag clears.
REQ-037 Reset SHALL abandon any in-flight transaction without a response. awready and arready are 1 from the first cycle after rst falls.
REQ-038 Memory contents SHALL NOT be affected by rst.

Verification
REQ-039 Write 0x010, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, awid=3 -> bresp=0, bid=3. Then read 0x010 with arid=5 -> rdata=0xDEADBEEF, rresp=0, rlast=1, rid=5.
REQ-040 4-beat write at 0x100 with data 1,2,3,4, then a 4-beat read with rready toggling -> rdata 1,2,3,4 in order, rlast on beat 4 only, rdata stable during stalls.
REQ-041 Write 0xFFFFFFFF to 0x020, then write 0x000000AA with wstrb=0x1 -> a read of 0x020 returns 0xFFFFFFAA.
REQ-042 Write to 0x1000 (index 1024) -> bresp=2'b10. A read of 0x1000 -> rdata=0, rresp=2'b10.
REQ-043 awlen=2 with wlast=1 on beat 1 -> three W beats accepted, then bresp=2'b10. A following clean write -> bresp=0.
REQ-044 Assert rst during beat 2 of a 4-beat read -> rvalid=0 in the next cycle, arready=1 after rst falls, and previously written memory data is intact.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: INCR-only full-width bursts, independent read/write FSMs,
// byte-strobed writes, SLVERR for out-of-range beats and wlast disagreement.
module axi4_slave_mem #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SHIFT  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (64'(a) >> SHIFT) < 64'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> SHIFT);
  endfunction

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_beat;
  logic              err, err_next, w_we, w_last_beat;

  assign w_last_beat = (w_beat == w_len);

  // Write next-state: beat count comes from awlen; wlast only feeds the error flag
  always_comb begin
    w_next   = w_state;
    err_next = err;
    w_we     = 1'b0;
    case (w_state)
      W_IDLE: if (awvalid && awready) w_next = W_DATA;
      W_DATA: if (wvalid && wready) begin
        w_we = in_range(w_addr);
        if (!in_range(w_addr) || (wlast != w_last_beat)) err_next = 1'b1;
        if (w_last_beat) w_next = W_RESP;
      end
      W_RESP: if (bvalid && bready) begin
        w_next   = W_IDLE;
        err_next = 1'b0;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, registered handshake outputs and burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      err     <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
    end else begin
      w_state <= w_next;
      err     <= err_next;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      bresp   <= ((w_next == W_RESP) && err_next) ? RESP_SLVERR : RESP_OKAY;
      if (w_state == W_IDLE && awvalid && awready) begin
        bid    <= awid;
        w_addr <= awaddr;
        w_len  <= awlen;
        w_beat <= '0;
      end else if (w_state == W_DATA && wvalid && wready) begin
        w_addr <= w_addr + BEAT_BYTES;
        w_beat <= w_beat + 8'd1;
      end
    end
  end

  // Byte-strobed storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] r_addr, r_ld_addr;
  logic [7:0]        r_len, r_beat;
  logic              r_load, r_ld_last;

  // Read next-state: load a beat on AR accept and on each non-final R handshake
  always_comb begin
    r_next    = r_state;
    r_load    = 1'b0;
    r_ld_addr = r_addr;
    r_ld_last = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid && arready) begin
        r_next    = R_DATA;
        r_load    = 1'b1;
        r_ld_addr = araddr;
        r_ld_last = (arlen == 8'd0);
      end
      R_DATA: if (rvalid && rready) begin
        if (rlast) begin
          r_next = R_IDLE;
        end else begin
          r_load    = 1'b1;
          r_ld_last = (r_beat == r_len);
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state and registered R payload; old data wins on same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (r_state == R_IDLE && arvalid && arready) begin
        rid    <= arid;
        r_len  <= arlen;
        r_beat <= 8'd1;
      end else if (r_load) begin
        r_beat <= r_beat + 8'd1;
      end
      if (r_load) begin
        r_addr <= r_ld_addr + BEAT_BYTES;
        rlast  <= r_ld_last;
        if (in_range(r_ld_addr)) begin
          rdata <= mem[word_idx(r_ld_addr)];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end else if (r_next == R_IDLE) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: directed scenarios plus random bursts
// checked against a byte-level memory model.
module tb_axi4_slave_mem;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ID_W      = 4;
  localparam int          MEM_WORDS = 1024;
  localparam int          TMO       = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi4_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word contents plus which bytes have ever been written
  logic [31:0] model [MEM_WORDS];
  logic [3:0]  kmask [MEM_WORDS];

  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  bit          wq_last[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  logic [3:0]  rq_id[$];
  logic [31:0] eq_data[$];
  logic [1:0]  eq_resp[$];
  logic [31:0] eq_mask[$];
  int rd_unstable;
  bit rd_first_ok, rd_tail_ok;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string what);
    checks++; errors++;
    $display("FAIL timeout_%s: no handshake within %0d cycles", what, TMO);
  endtask

  function automatic void clear_beats();
    wq_data.delete(); wq_strb.delete(); wq_last.delete();
  endfunction

  function automatic void push_beat(input logic [31:0] d, input logic [3:0] s, input bit l);
    wq_data.push_back(d); wq_strb.push_back(s); wq_last.push_back(l);
  endfunction

  // Applies the queued burst to the model, returns the expected bresp
  function automatic logic [1:0] model_write(input logic [15:0] addr, input logic [7:0] len);
    logic [15:0] a = addr;
    bit err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      int idx = int'(a >> 2);
      if (wq_last[i] != (i == int'(len))) err = 1;
      if (idx >= MEM_WORDS) err = 1;
      else begin
        for (int b = 0; b < 4; b++)
          if (wq_strb[i][b]) model[idx][b*8 +: 8] = wq_data[i][b*8 +: 8];
        kmask[idx] = kmask[idx] | wq_strb[i];
      end
      a = a + 16'd4;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic void exp_read(input logic [15:0] addr, input logic [7:0] len);
    logic [15:0] a = addr;
    eq_data.delete(); eq_resp.delete(); eq_mask.delete();
    for (int i = 0; i <= int'(len); i++) begin
      int idx = int'(a >> 2);
      if (idx >= MEM_WORDS) begin
        eq_data.push_back(32'd0); eq_resp.push_back(2'b10); eq_mask.push_back(32'hFFFF_FFFF);
      end else begin
        eq_data.push_back(model[idx]); eq_resp.push_back(2'b00);
        eq_mask.push_back({{8{kmask[idx][3]}}, {8{kmask[idx][2]}}, {8{kmask[idx][1]}}, {8{kmask[idx][0]}}});
      end
      a = a + 16'd4;
    end
  endfunction

  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id,
                           output logic [1:0] resp, output logic [3:0] rbid);
    int n;
    resp = 2'b11; rbid = '0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0; while (awready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin timeout("awready"); awvalid = 1'b0; return; end
    tick(); awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = wq_last[i]; wvalid = 1'b1;
      n = 0; while (wready !== 1'b1 && n < TMO) begin tick(); n++; end
      if (n >= TMO) begin timeout("wready"); wvalid = 1'b0; return; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0; while (bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin timeout("bvalid"); bready = 1'b0; return; end
    resp = bresp; rbid = bid;
    tick(); bready = 1'b0;
  endtask

  // stall: 0 none, 1 fixed 1-2 cycle stalls, 2 random stalls
  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id, input int stall);
    int n, k;
    logic [40:0] snap;
    rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete();
    rd_unstable = 0; rd_first_ok = 1; rd_tail_ok = 1;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0; while (arready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin timeout("arready"); arvalid = 1'b0; return; end
    tick(); arvalid = 1'b0;
    if (rvalid !== 1'b1) rd_first_ok = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0; while (rvalid !== 1'b1 && n < TMO) begin tick(); n++; end
      if (n >= TMO) begin timeout("rvalid"); return; end
      k = (stall == 1) ? 1 + (i % 2) : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < k; s++) begin
        snap = {rvalid, rid, rdata, rresp, rlast, 1'b0};
        rready = 1'b0; tick();
        if ({rvalid, rid, rdata, rresp, rlast, 1'b0} !== snap) rd_unstable++;
      end
      rq_data.push_back(rdata); rq_resp.push_back(rresp); rq_last.push_back(rlast); rq_id.push_back(rid);
      rready = 1'b1; tick(); rready = 1'b0;
    end
    if (rvalid !== 1'b0) rd_tail_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got aw%b w%b b%b ar%b r%b l%b bid%0h bresp%0h rid%0h rresp%0h rdata%h, expected all zero",
               awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      errors++;
      $display("FAIL post_reset_ready: got {aw,ar,w,b,r}=%b expected 11000", {awready, arready, wready, bvalid, rvalid});
    end
  endtask

  task automatic test_single();
    logic [1:0] resp, er; logic [3:0] b;
    clear_beats(); push_beat(32'hDEAD_BEEF, 4'hF, 1);
    er = model_write(16'h0010, 8'd0);
    axi_write(16'h0010, 8'd0, 4'd3, resp, b);
    checks++; if (resp !== er) begin errors++; $display("FAIL single_bresp: got %0d expected %0d", resp, er); end
    checks++; if (b !== 4'd3) begin errors++; $display("FAIL single_bid: got %0d expected 3", b); end
    axi_read(16'h0010, 8'd0, 4'd5, 0);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== 32'hDEAD_BEEF || rq_resp[0] !== 2'b00 || rq_last[0] !== 1'b1 || rq_id[0] !== 4'd5) begin
      errors++;
      $display("FAIL single_read: got %0d beats data %h resp %0d last %0d id %0d, expected data deadbeef resp 0 last 1 id 5",
               rq_data.size(), rq_data[0], rq_resp[0], rq_last[0], rq_id[0]);
    end
    checks++;
    if (!rd_first_ok || !rd_tail_ok) begin
      errors++; $display("FAIL single_timing: first_beat_ok %0d rvalid_low_after_ok %0d, expected 1 1", rd_first_ok, rd_tail_ok);
    end
  endtask

  task automatic test_burst();
    logic [1:0] resp, er; logic [3:0] b;
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat(32'(i + 1), 4'hF, i == 3);
    er = model_write(16'h0100, 8'd3);
    axi_write(16'h0100, 8'd3, 4'd7, resp, b);
    checks++; if (resp !== er || b !== 4'd7) begin errors++; $display("FAIL burst_bresp: got resp %0d id %0d expected %0d 7", resp, b, er); end
    axi_read(16'h0100, 8'd3, 4'd9, 1);
    checks++; if (rq_data.size() != 4) begin errors++; $display("FAIL burst_beats: got %0d expected 4", rq_data.size()); end
    for (int i = 0; i < rq_data.size(); i++) begin
      checks++;
      if (rq_data[i] !== 32'(i + 1) || rq_last[i] !== (i == 3) || rq_resp[i] !== 2'b00 || rq_id[i] !== 4'd9) begin
        errors++;
        $display("FAIL burst_beat%0d: got data %h last %0d resp %0d id %0d, expected data %h last %0d resp 0 id 9",
                 i, rq_data[i], rq_last[i], rq_resp[i], rq_id[i], 32'(i + 1), (i == 3));
      end
    end
    checks++;
    if (rd_unstable !== 0 || !rd_tail_ok) begin
      errors++; $display("FAIL burst_stall_stable: got %0d unstable stalls tail_ok %0d, expected 0 1", rd_unstable, rd_tail_ok);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, r2; logic [3:0] b;
    clear_beats(); push_beat(32'hFFFF_FFFF, 4'hF, 1); void'(model_write(16'h0020, 8'd0));
    axi_write(16'h0020, 8'd0, 4'd1, resp, b);
    clear_beats(); push_beat(32'h0000_00AA, 4'h1, 1); void'(model_write(16'h0020, 8'd0));
    axi_write(16'h0020, 8'd0, 4'd1, r2, b);
    axi_read(16'h0020, 8'd0, 4'd2, 0);
    checks++;
    if (resp !== 2'b00 || r2 !== 2'b00 || rq_data.size() != 1 || rq_data[0] !== 32'hFFFF_FFAA) begin
      errors++; $display("FAIL strobe: got bresp %0d/%0d data %h, expected 0/0 ffffffaa", resp, r2, rq_data[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [3:0] b;
    clear_beats(); push_beat(32'h1234_5678, 4'hF, 1); void'(model_write(16'h1000, 8'd0));
    axi_write(16'h1000, 8'd0, 4'd6, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_write_bresp: got %0d expected 2", resp); end
    axi_read(16'h1000, 8'd0, 4'd6, 0);
    checks++;
    if (rq_data[0] !== 32'd0 || rq_resp[0] !== 2'b10) begin
      errors++; $display("FAIL oor_read: got data %h resp %0d expected 0 2", rq_data[0], rq_resp[0]);
    end
    // Burst straddling the top word: first beat lands, second is dropped
    clear_beats(); push_beat(32'h1111_1111, 4'hF, 0); push_beat(32'h2222_2222, 4'hF, 1);
    void'(model_write(16'h0FFC, 8'd1));
    axi_write(16'h0FFC, 8'd1, 4'd6, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL edge_write_bresp: got %0d expected 2", resp); end
    axi_read(16'h0FFC, 8'd1, 4'd8, 0);
    checks++;
    if (rq_data.size() != 2 || rq_data[0] !== 32'h1111_1111 || rq_resp[0] !== 2'b00 ||
        rq_data[1] !== 32'd0 || rq_resp[1] !== 2'b10 || rq_last[0] !== 1'b0 || rq_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_read: got %h/%0d/%0d %h/%0d/%0d expected 11111111/0/0 00000000/2/1",
               rq_data[0], rq_resp[0], rq_last[0], rq_data[1], rq_resp[1], rq_last[1]);
    end
  endtask

  task automatic test_wlast();
    logic [1:0] resp; logic [3:0] b;
    clear_beats();
    push_beat(32'hA0A0_0001, 4'hF, 0); push_beat(32'hA0A0_0002, 4'hF, 1); push_beat(32'hA0A0_0003, 4'hF, 0);
    void'(model_write(16'h0200, 8'd2));
    axi_write(16'h0200, 8'd2, 4'd4, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_early_bresp: got %0d expected 2", resp); end
    axi_read(16'h0200, 8'd2, 4'd4, 0);
    exp_read(16'h0200, 8'd2);
    checks++;
    if (rq_data.size() != 3 || rq_data[0] !== eq_data[0] || rq_data[1] !== eq_data[1] || rq_data[2] !== eq_data[2]) begin
      errors++; $display("FAIL wlast_beats_written: got %h %h %h expected %h %h %h",
                         rq_data[0], rq_data[1], rq_data[2], eq_data[0], eq_data[1], eq_data[2]);
    end
    clear_beats(); push_beat(32'h0BAD_0BAD, 4'hF, 1); void'(model_write(16'h0200, 8'd0));
    axi_write(16'h0200, 8'd0, 4'd4, resp, b);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wlast_clean_after: got %0d expected 0", resp); end
    clear_beats(); push_beat(32'h0C0C_0C0C, 4'hF, 0); void'(model_write(16'h0204, 8'd0));
    axi_write(16'h0204, 8'd0, 4'd4, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_missing: got %0d expected 2", resp); end
  endtask

  task automatic test_concurrent();
    logic [31:0] old;
    logic [1:0] resp;
    int n;
    old = model[16'h0100 >> 2];
    awid = 4'd2; awaddr = 16'h0100; awlen = 8'd0; awvalid = 1'b1;
    n = 0; while (awready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin timeout("conc_aw"); awvalid = 1'b0; return; end
    tick(); awvalid = 1'b0;
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd4; araddr = 16'h0100; arlen = 8'd0; arvalid = 1'b1;
    checks++;
    if ({wready, arready} !== 2'b11) begin errors++; $display("FAIL conc_ready: got {w,ar}=%b expected 11", {wready, arready}); end
    tick(); wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      errors++; $display("FAIL conc_old_data: got rvalid %0d data %h expected 1 %h", rvalid, rdata, old);
    end
    resp = bresp;
    checks++;
    if (bvalid !== 1'b1 || resp !== 2'b00) begin errors++; $display("FAIL conc_bresp: got bvalid %0d resp %0d expected 1 0", bvalid, resp); end
    rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
    clear_beats(); push_beat(32'h5555_AAAA, 4'hF, 1); void'(model_write(16'h0100, 8'd0));
    axi_read(16'h0100, 8'd0, 4'd4, 0);
    checks++;
    if (rq_data[0] !== 32'h5555_AAAA) begin errors++; $display("FAIL conc_new_data: got %h expected 5555aaaa", rq_data[0]); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    arid = 4'd1; araddr = 16'h0100; arlen = 8'd3; arvalid = 1'b1;
    n = 0; while (arready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin timeout("rst_ar"); arvalid = 1'b0; return; end
    tick(); arvalid = 1'b0;
    rready = 1'b1; tick(); rready = 1'b0;
    rst = 1'b1; tick();
    checks++;
    if ({rvalid, rlast, arready, awready} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_read: got {rvalid,rlast,arready,awready}=%b expected 0000", {rvalid, rlast, arready, awready});
    end
    rst = 1'b0; tick();
    checks++;
    if ({arready, awready, rvalid} !== 3'b110) begin
      errors++; $display("FAIL rst_release_ready: got {ar,aw,rvalid}=%b expected 110", {arready, awready, rvalid});
    end
    axi_read(16'h0100, 8'd3, 4'd1, 0);
    exp_read(16'h0100, 8'd3);
    checks++;
    if (rq_data.size() != 4 || rq_data[0] !== eq_data[0] || rq_data[1] !== eq_data[1] ||
        rq_data[2] !== eq_data[2] || rq_data[3] !== eq_data[3]) begin
      errors++; $display("FAIL rst_mem_intact: got %h %h %h %h expected %h %h %h %h",
                         rq_data[0], rq_data[1], rq_data[2], rq_data[3], eq_data[0], eq_data[1], eq_data[2], eq_data[3]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, er; logic [3:0] b, id;
    logic [15:0] addr; logic [7:0] len;
    int bad, badpos;
    for (int it = 0; it < 24; it++) begin
      addr = 16'($urandom_range(0, 1100) << 2);
      len  = 8'($urandom_range(0, 5));
      id   = 4'($urandom_range(0, 15));
      bad  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      badpos = int'($urandom_range(0, int'(len)));
      clear_beats();
      for (int i = 0; i <= int'(len); i++)
        push_beat($urandom, 4'($urandom_range(1, 15)), (i == int'(len)) ^ (bad == 1 && i == badpos));
      er = model_write(addr, len);
      axi_write(addr, len, id, resp, b);
      checks++;
      if (resp !== er || b !== id) begin
        errors++; $display("FAIL rand_write%0d: got resp %0d id %0d expected %0d %0d", it, resp, b, er, id);
      end
      addr = (it % 2 == 0) ? addr : 16'($urandom_range(0, 1100) << 2);
      len  = 8'($urandom_range(0, 6));
      id   = 4'($urandom_range(0, 15));
      axi_read(addr, len, id, 2);
      exp_read(addr, len);
      checks++;
      if (rq_data.size() != eq_data.size() || rd_unstable != 0 || !rd_first_ok || !rd_tail_ok) begin
        errors++; $display("FAIL rand_read%0d_shape: got %0d beats unstable %0d first %0d tail %0d expected %0d 0 1 1",
                           it, rq_data.size(), rd_unstable, rd_first_ok, rd_tail_ok, eq_data.size());
      end
      for (int i = 0; i < eq_data.size() && i < rq_data.size(); i++) begin
        checks++;
        if (((rq_data[i] ^ eq_data[i]) & eq_mask[i]) !== 32'd0 || rq_resp[i] !== eq_resp[i] ||
            rq_last[i] !== (i == eq_data.size() - 1) || rq_id[i] !== id) begin
          errors++;
          $display("FAIL rand_read%0d_beat%0d: got data %h resp %0d last %0d id %0d expected data %h mask %h resp %0d last %0d id %0d",
                   it, i, rq_data[i], rq_resp[i], rq_last[i], rq_id[i], eq_data[i], eq_mask[i], eq_resp[i],
                   (i == eq_data.size() - 1), id);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin model[i] = '0; kmask[i] = '0; end
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_out_of_range();
    test_wlast();
    test_concurrent();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
